// File: rtl/bp_be_pkg.sv
// bp_be_pkg: backend types shared by the long-latency scoreboard.
// Holds the issue packet, the scoreboard entry and the issue packet width.
package bp_be_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_multicore_1_cfg,
    e_bp_unicore_cfg
  } bp_params_e;

  typedef struct packed {
    logic       irs1_v;
    logic       irs2_v;
    logic       frs1_v;
    logic       frs2_v;
    logic       frs3_v;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic [4:0] rs3_addr;
    logic       long_v;
  } bp_be_issue_pkt_s;

  localparam int issue_pkt_width_lp = $bits(bp_be_issue_pkt_s);

  typedef struct packed {
    logic       frd;
    logic [4:0] rd_addr;
  } bp_be_long_sb_entry_s;

endpackage

// File: rtl/bp_be_long_sb_fifo.sv
// bp_be_long_sb_fifo: in-order store of outstanding long-op destinations.
// Ports: clk_i, reset_n_i (async, active-low), push_i/data_i enqueue,
// pop_i dequeues the head, head_o is the oldest entry, full_o/empty_o status.
// A pop on an empty FIFO is ignored; a push while full is taken only if a
// pop frees the slot in the same cycle.
module bp_be_long_sb_fifo
  import bp_be_pkg::*;
#(
  parameter int els_p = 4
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 push_i,
  input  bp_be_long_sb_entry_s data_i,
  input  logic                 pop_i,
  output bp_be_long_sb_entry_s head_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int ptr_w = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w = $clog2(els_p + 1);
  localparam logic [ptr_w-1:0] last_ptr = ptr_w'(els_p - 1);
  localparam logic [cnt_w-1:0] max_cnt = cnt_w'(els_p);

  bp_be_long_sb_entry_s mem [els_p];
  logic [ptr_w-1:0] rptr, wptr;
  logic [cnt_w-1:0] cnt;
  logic do_push, do_pop;

  assign full_o  = (cnt == max_cnt);
  assign empty_o = (cnt == '0);
  assign head_o  = mem[rptr];
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= (wptr == last_ptr) ? '0 : wptr + 1'b1;
      if (do_pop) rptr <= (rptr == last_ptr) ? '0 : rptr + 1'b1;
      cnt <= cnt + cnt_w'(do_push) - cnt_w'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= data_i;
  end

endmodule

// File: rtl/bp_be_long_scoreboard.sv
// bp_be_long_scoreboard: stalls issue on RAW hazards against outstanding long ops.
// Ports: clk_i, reset_n_i (async, active-low), issue_pkt_i sources + long_v,
// rd_addr_i/frd_i destination, dispatch_v_i issue handshake, wb_v_i long-unit
// writeback of the oldest op, hazard_o stall, full_o capacity, err_o sticky
// writeback-on-empty error.
// Macro BP_BE_SCOREBOARD_WB_BYPASS_EN: when defined, a register being written
// back this cycle no longer stalls its consumers, and that pop frees a slot.
module bp_be_long_scoreboard
  import bp_be_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_multicore_1_cfg,
  parameter int         long_els_p  = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic [issue_pkt_width_lp-1:0] issue_pkt_i,
  input  logic [4:0]                    rd_addr_i,
  input  logic                          frd_i,
  input  logic                          dispatch_v_i,
  input  logic                          wb_v_i,
  output logic                          hazard_o,
  output logic                          full_o,
  output logic                          err_o
);

  bp_be_issue_pkt_s pkt;
  bp_be_long_sb_entry_s head, entry;
  logic [31:0] irf_pend_r, frf_pend_r;
  logic [31:0] irf_set, frf_set, irf_clr, frf_clr;
  logic [31:0] irf_chk, frf_chk;
  logic empty, push_v, pop_v, full_chk, src_hit;

  assign pkt   = bp_be_issue_pkt_s'(issue_pkt_i);
  assign entry = '{frd: frd_i, rd_addr: rd_addr_i};
  assign pop_v  = wb_v_i & ~empty;
  assign push_v = dispatch_v_i & pkt.long_v & ~hazard_o;

  // x0 is hardwired zero, so it is never marked pending
  assign irf_set = (push_v & ~frd_i & (rd_addr_i != 5'd0)) ? (32'b1 << rd_addr_i) : '0;
  assign frf_set = (push_v & frd_i) ? (32'b1 << rd_addr_i) : '0;
  assign irf_clr = (pop_v & ~head.frd) ? (32'b1 << head.rd_addr) : '0;
  assign frf_clr = (pop_v & head.frd) ? (32'b1 << head.rd_addr) : '0;

`ifdef BP_BE_SCOREBOARD_WB_BYPASS_EN
  assign irf_chk  = irf_pend_r & ~irf_clr;
  assign frf_chk  = frf_pend_r & ~frf_clr;
  assign full_chk = full_o & ~pop_v;
`else
  assign irf_chk  = irf_pend_r;
  assign frf_chk  = frf_pend_r;
  assign full_chk = full_o;
`endif

  assign src_hit = (pkt.irs1_v & irf_chk[pkt.rs1_addr])
                 | (pkt.irs2_v & irf_chk[pkt.rs2_addr])
                 | (pkt.frs1_v & frf_chk[pkt.rs1_addr])
                 | (pkt.frs2_v & frf_chk[pkt.rs2_addr])
                 | (pkt.frs3_v & frf_chk[pkt.rs3_addr]);
  assign hazard_o = src_hit | (pkt.long_v & full_chk);

  bp_be_long_sb_fifo #(.els_p(long_els_p)) fifo (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .push_i   (push_v),
    .data_i   (entry),
    .pop_i    (wb_v_i),
    .head_o   (head),
    .full_o   (full_o),
    .empty_o  (empty)
  );

  // clear before set so a same-cycle pop and push of one register leaves it pending
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      irf_pend_r <= '0;
      frf_pend_r <= '0;
      err_o      <= 1'b0;
    end else begin
      irf_pend_r <= (irf_pend_r & ~irf_clr) | irf_set;
      frf_pend_r <= (frf_pend_r & ~frf_clr) | frf_set;
      if (wb_v_i & empty) err_o <= 1'b1;
    end
  end

endmodule

// File: doc/bp_be_long_scoreboard.md
BP_BE_LONG_SCOREBOARD -- requirements
Module: bp_be_long_scoreboard

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_multicore_1_cfg, meaning the processor configuration.
REQ-002 SHALL have parameter long_els_p, default 4, meaning the maximum outstanding long-latency ops (div/rem/fdiv/fsqrt).
REQ-003 SHALL have port clk_i  in  1  meaning the single clock; all state rises on its posedge.
REQ-004 SHALL have port reset_n_i  in  1  meaning reset, asynchronous and active-low.
REQ-005 SHALL have port issue_pkt_i  in  issue_pkt_width_lp  meaning the registered issue packet (irs1_v/irs2_v/frs1_v/frs2_v/frs3_v, rs1/rs2/rs3 addr, long_v).
REQ-006 SHALL have port rd_addr_i  in  5  meaning the issuing instruction's destination register.
REQ-007 SHALL have port frd_i  in  1  meaning the destination is FP (1) or integer (0).
REQ-008 SHALL have port dispatch_v_i  in  1  meaning the issuing instruction leaves issue this cycle.
REQ-009 SHALL have port wb_v_i  in  1  meaning the long unit writes back its oldest op this cycle.
REQ-010 SHALL have port hazard_o  out  1  meaning the issuing instruction must stall.
REQ-011 SHALL have port full_o  out  1  meaning long_els_p ops are outstanding.
REQ-012 SHALL have port err_o  out  1  meaning sticky protocol error.

Function
REQ-013 SHALL keep 32-bit pending vectors irf_pend_r and frf_pend_r plus an in-order FIFO of long_els_p entries {frd, rd_addr}.
REQ-014 SHALL assert hazard_o combinationally when any valid source (irs*/frs* with its addr) hits a set pending bit, or when long_v & full_o.
REQ-015 SHALL treat integer x0 as never pending; FP f0 is an ordinary register.
REQ-016 SHALL, on dispatch_v_i & issue_pkt_i.long_v & ~hazard_o, push {frd_i, rd_addr_i} and set the matching pending bit, visible next cycle.
REQ-017 SHALL ignore dispatch_v_i while hazard_o=1 (no push, no set).
REQ-018 SHALL, on wb_v_i with FIFO non-empty, pop the head and clear its pending bit next cycle.
REQ-019 SHALL, on simultaneous push and pop naming the same register, end with that bit set (set wins).
REQ-020 SHALL keep occupancy unchanged on simultaneous push and pop, including when full (pop frees the slot the push takes).
REQ-021 SHALL hold occupancy in $clog2(long_els_p+1) bits, with read/write pointers wrapping modulo long_els_p.
REQ-022 SHALL, on wb_v_i with FIFO empty, change nothing and set err_o, which stays set until reset.
REQ-023 SHALL drive full_o = (occupancy == long_els_p), registered-state derived, zero latency.

Reset
REQ-024 SHALL, on reset_n_i=0 at any time including mid-operation, immediately clear both pending vectors, pointers, occupancy and err_o; hazard_o then depends only on issue_pkt_i (0 unless long_v with long_els_p=0).

Configuration
REQ-025 SHALL, with BP_BE_SCOREBOARD_WB_BYPASS_EN defined, exclude the register popped this cycle (wb_v_i & head match) from the hazard check of REQ-014, and count a pop as freeing a slot for the long_v & full_o hazard.
REQ-026 SHALL, without BP_BE_SCOREBOARD_WB_BYPASS_EN, compute hazard_o purely from registered state, with a one-cycle extra stall after writeback.

Structure
REQ-027 SHALL take bp_be_issue_pkt_s and its width macro from bp_be_pkg/bp_be_defines; the scoreboard entry struct bp_be_long_sb_entry_s SHALL be added to bp_be_pkg.
REQ-028 SHALL implement the in-order destination store as one sub-module, bp_be_long_sb_fifo (async active-low reset, push/pop/full/empty/head).

Verification
REQ-029 SHALL cover: reset, dispatch long x5 -> next cycle rs1=x5 source gives hazard_o=1; wb_v_i -> hazard_o=0 the same cycle (bypass on) or next cycle (bypass off).
REQ-030 SHALL cover: 4 long dispatches x1..x4 -> full_o=1; a 5th long gets hazard_o=1; wb frees x1 first (in-order pop).
REQ-031 SHALL cover: full, simultaneous pop of x1 and push of f1 -> occupancy stays 4, x1 clear, f1 set.
REQ-032 SHALL cover: pending x7, simultaneous pop x7 and push x7 -> x7 remains pending.
REQ-033 SHALL cover: wb_v_i on empty -> err_o=1 and sticky; source x0 with a long op to x0 -> no hazard.
REQ-034 SHALL cover: reset_n_i pulsed low with 3 outstanding -> full_o=0, all pending cleared, err_o=0 without waiting for a clock edge.
